// File: rtl/tx_link_scheduler.sv
// Symbol-rate scheduler: arbitrates two frame requesters onto one 8b/10b symbol stream.
// Emits IDLE/STP/payload/END symbols and inserts SKP ordered sets between frames.
module tx_link_scheduler #(
  parameter int unsigned SLOT         = 10,
  parameter int unsigned SKP_INTERVAL = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enb,
  input  logic       reqA,
  input  logic       reqB,
  input  logic [3:0] lenA,
  input  logic [3:0] lenB,
  input  logic [7:0] dataA,
  input  logic [7:0] dataB,
  output logic       grantA,
  output logic       grantB,
  output logic       popA,
  output logic       popB,
  output logic [7:0] dataOut,
  output logic       K,
  output logic       symStb,
  output logic       busy
);

  localparam int unsigned SW = (SLOT > 1) ? $clog2(SLOT) : 1;
  localparam int unsigned CW = $clog2(SKP_INTERVAL + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_STP  = 3'd1;
  localparam logic [2:0] S_PAY  = 3'd2;
  localparam logic [2:0] S_END  = 3'd3;
  localparam logic [2:0] S_COM  = 3'd4;
  localparam logic [2:0] S_SKP  = 3'd5;

  logic [SW-1:0] r_slot;
  logic [2:0]    r_state;
  logic          r_owner;  // 0 = A, 1 = B
  logic          r_rr;     // round-robin pointer: requester preferred on contention
  logic [3:0]    r_rem;
  logic [CW-1:0] r_skp;
  logic [7:0]    r_data;
  logic          r_k;
  logic          r_stb;
  logic          r_popA;
  logic          r_popB;

  logic          w_bnd;
  logic          w_skp_due;
  logic          w_pick;
  logic [2:0]    w_state_d;
  logic          w_owner_d;
  logic          w_rr_d;
  logic [3:0]    w_rem_d;
  logic [CW-1:0] w_skp_d;
  logic [7:0]    w_data_d;
  logic          w_k_d;
  logic          w_popA_d;
  logic          w_popB_d;

  assign w_bnd     = enb && (r_slot == SW'(SLOT - 1));
  assign w_skp_due = (r_skp >= CW'(SKP_INTERVAL));
  assign w_pick    = (reqA && reqB) ? r_rr : reqB;

  always_comb begin
    w_state_d = r_state;
    w_owner_d = r_owner;
    w_rr_d    = r_rr;
    w_rem_d   = r_rem;
    w_popA_d  = 1'b0;
    w_popB_d  = 1'b0;
    case (r_state)
      // Frame gaps are the only points where SKP sets or new frames may start.
      S_IDLE, S_END, S_SKP: begin
        if (w_skp_due) begin
          w_state_d = S_COM;
        end else if (reqA || reqB) begin
          w_state_d = S_STP;
          w_owner_d = w_pick;
          w_rr_d    = ~w_pick;
          w_rem_d   = w_pick ? lenB : lenA;
        end else begin
          w_state_d = S_IDLE;
        end
      end
      S_COM: w_state_d = S_SKP;
      S_STP, S_PAY: begin
        if (r_rem == 4'd0) begin
          w_state_d = S_END;
        end else begin
          w_state_d = S_PAY;
          w_rem_d   = r_rem - 4'd1;
          w_popA_d  = ~r_owner;
          w_popB_d  = r_owner;
        end
      end
      default: w_state_d = S_IDLE;
    endcase
  end

  always_comb begin
    w_data_d = 8'h7C;
    w_k_d    = 1'b1;
    case (w_state_d)
      S_STP:   w_data_d = 8'hFB;
      S_PAY: begin
        w_data_d = w_owner_d ? dataB : dataA;
        w_k_d    = 1'b0;
      end
      S_END:   w_data_d = 8'hFD;
      S_COM:   w_data_d = 8'hBC;
      S_SKP:   w_data_d = 8'h1C;
      default: w_data_d = 8'h7C;
    endcase
  end

  always_comb begin
    if (w_state_d == S_SKP) begin
      w_skp_d = '0;
    end else if (r_skp < CW'(SKP_INTERVAL)) begin
      w_skp_d = r_skp + CW'(1);
    end else begin
      w_skp_d = r_skp;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_slot  <= '0;
      r_state <= S_IDLE;
      r_owner <= 1'b0;
      r_rr    <= 1'b0;
      r_rem   <= 4'd0;
      r_skp   <= '0;
      r_data  <= 8'h7C;
      r_k     <= 1'b1;
      r_stb   <= 1'b0;
      r_popA  <= 1'b0;
      r_popB  <= 1'b0;
    end else if (enb) begin
      r_slot <= w_bnd ? '0 : r_slot + SW'(1);
      r_stb  <= w_bnd;
      r_popA <= w_bnd & w_popA_d;
      r_popB <= w_bnd & w_popB_d;
      if (w_bnd) begin
        r_state <= w_state_d;
        r_owner <= w_owner_d;
        r_rr    <= w_rr_d;
        r_rem   <= w_rem_d;
        r_skp   <= w_skp_d;
        r_data  <= w_data_d;
        r_k     <= w_k_d;
      end
    end
  end

  // Pulses are held while disabled, so gate them to keep them silent during the freeze.
  assign symStb  = r_stb & enb;
  assign popA    = r_popA & enb;
  assign popB    = r_popB & enb;
  assign dataOut = r_data;
  assign K       = r_k;
  assign grantA  = (r_state == S_STP || r_state == S_PAY || r_state == S_END) && !r_owner;
  assign grantB  = (r_state == S_STP || r_state == S_PAY || r_state == S_END) && r_owner;
  assign busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_tx_link_scheduler.sv
// Directed bench for tx_link_scheduler: one task per scenario with inline expected values.
module tb_tx_link_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enb = 1'b1;
  logic       reqA = 1'b0, reqB = 1'b0;
  logic [3:0] lenA = 4'd0, lenB = 4'd0;
  logic [7:0] dataA = 8'd0, dataB = 8'd0;

  logic       grantA, grantB, popA, popB, K, symStb, busy;
  logic [7:0] dataOut;
  logic       grantA_8, grantB_8, popA_8, popB_8, K_8, symStb_8, busy_8;
  logic [7:0] dataOut_8;

  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   use8 = 1'b0;
  logic [7:0] bytesA [16];
  logic [7:0] bytesB [16];
  int   idxA = 0, idxB = 0;

  tx_link_scheduler dut (
    .clk(clk), .rst(rst), .enb(enb), .reqA(reqA), .reqB(reqB), .lenA(lenA), .lenB(lenB),
    .dataA(dataA), .dataB(dataB), .grantA(grantA), .grantB(grantB), .popA(popA), .popB(popB),
    .dataOut(dataOut), .K(K), .symStb(symStb), .busy(busy)
  );

  tx_link_scheduler #(.SLOT(10), .SKP_INTERVAL(8)) dut8 (
    .clk(clk), .rst(rst), .enb(enb), .reqA(reqA), .reqB(reqB), .lenA(lenA), .lenB(lenB),
    .dataA(dataA), .dataB(dataB), .grantA(grantA_8), .grantB(grantB_8), .popA(popA_8),
    .popB(popB_8), .dataOut(dataOut_8), .K(K_8), .symStb(symStb_8), .busy(busy_8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Requester model: advance to the next byte after each pop.
  always @(negedge clk) begin
    if (!rst) begin
      idxA = 0;
      idxB = 0;
    end else begin
      if (use8 ? popA_8 : popA) idxA = idxA + 1;
      if (use8 ? popB_8 : popB) idxB = idxB + 1;
    end
    dataA = bytesA[idxA % 16];
    dataB = bytesB[idxB % 16];
  end

  task automatic wait_stb(input bit d8, output int n);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if ((d8 ? symStb_8 : symStb) === 1'b1) begin
        n = i;
        break;
      end
    end
    if (n == 0) begin
      n_chk++; n_fail++;
      $display("FAIL symstb_timeout: no symStb within 40 cycles");
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    enb = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    int n;
    #1 rst = 1'b0;
    @(negedge clk);
    n_chk++; if ({K, dataOut} !== 9'h17C) begin
      n_fail++; $display("FAIL reset_sym got %h want 17c", {K, dataOut}); end
    n_chk++; if ({symStb, popA, popB} !== 3'b000) begin
      n_fail++; $display("FAIL reset_pulses got %b want 000", {symStb, popA, popB}); end
    n_chk++; if ({grantA, grantB, busy} !== 3'b000) begin
      n_fail++; $display("FAIL reset_grant_busy got %b want 000", {grantA, grantB, busy}); end
    rst = 1'b1;
    wait_stb(1'b0, n);
    n_chk++; if (n != 10 || {K, dataOut} !== 9'h17C) begin
      n_fail++; $display("FAIL reset_first_idle got n=%0d sym=%h want n=10 sym=17c",
                         n, {K, dataOut}); end
  endtask

  task automatic test_single_frame();
    logic [8:0] ex [6];
    bit g [6];
    bit p [6];
    int n;
    ex = '{9'h1FB, 9'h011, 9'h022, 9'h033, 9'h1FD, 9'h17C};
    g  = '{1, 1, 1, 1, 1, 0};
    p  = '{0, 1, 1, 1, 0, 0};
    bytesA[0] = 8'h11; bytesA[1] = 8'h22; bytesA[2] = 8'h33;
    do_reset();
    reqA = 1'b1; lenA = 4'd3;
    for (int i = 0; i < 6; i++) begin
      wait_stb(1'b0, n);
      if (i == 0) reqA = 1'b0;
      n_chk++; if ({K, dataOut} !== ex[i] || grantA !== g[i] || popA !== p[i]) begin
        n_fail++; $display("FAIL single_sym%0d got sym=%h gA=%b pop=%b want sym=%h gA=%b pop=%b",
                           i, {K, dataOut}, grantA, popA, ex[i], g[i], p[i]); end
      if (i > 0) begin
        n_chk++; if (n != 10) begin
          n_fail++; $display("FAIL single_spacing%0d got %0d want 10", i, n); end
      end
    end
  endtask

  task automatic test_contention();
    logic [8:0] ex [12];
    bit ga [12];
    int n;
    ex = '{9'h1FB, 9'h0A0, 9'h1FD, 9'h1FB, 9'h0B0, 9'h1FD,
           9'h1FB, 9'h0A1, 9'h1FD, 9'h1FB, 9'h0B1, 9'h1FD};
    ga = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0};
    for (int i = 0; i < 16; i++) begin
      bytesA[i] = 8'hA0 + 8'(i);
      bytesB[i] = 8'hB0 + 8'(i);
    end
    do_reset();
    reqA = 1'b1; reqB = 1'b1; lenA = 4'd1; lenB = 4'd1;
    for (int i = 0; i < 12; i++) begin
      wait_stb(1'b0, n);
      if (i == 11) begin reqA = 1'b0; reqB = 1'b0; end
      n_chk++; if ({K, dataOut} !== ex[i] || grantA !== ga[i] || grantB !== !ga[i]) begin
        n_fail++; $display("FAIL contention_sym%0d got sym=%h gA=%b gB=%b want sym=%h gA=%b",
                           i, {K, dataOut}, grantA, grantB, ex[i], ga[i]); end
    end
  endtask

  task automatic test_len0();
    logic [8:0] ex [3];
    bit g [3];
    int n;
    ex = '{9'h1FB, 9'h1FD, 9'h17C};
    g  = '{1, 1, 0};
    do_reset();
    reqB = 1'b1; lenB = 4'd0;
    for (int i = 0; i < 3; i++) begin
      wait_stb(1'b0, n);
      if (i == 0) reqB = 1'b0;
      n_chk++; if ({K, dataOut} !== ex[i] || grantB !== g[i] || popB !== 1'b0) begin
        n_fail++; $display("FAIL len0_sym%0d got sym=%h gB=%b pop=%b want sym=%h gB=%b pop=0",
                           i, {K, dataOut}, grantB, popB, ex[i], g[i]); end
    end
  endtask

  task automatic test_skp();
    logic [8:0] ex [20];
    bit g [20];
    int n;
    ex[0] = 9'h1FB;
    for (int i = 1; i <= 15; i++) ex[i] = {1'b0, 8'h3F + 8'(i)};
    ex[16] = 9'h1FD; ex[17] = 9'h1BC; ex[18] = 9'h11C; ex[19] = 9'h1FB;
    for (int i = 0; i < 20; i++) g[i] = !(i == 17 || i == 18);
    for (int i = 0; i < 16; i++) bytesA[i] = 8'h40 + 8'(i);
    use8 = 1'b1;
    do_reset();
    reqA = 1'b1; lenA = 4'd15;
    for (int i = 0; i < 20; i++) begin
      wait_stb(1'b1, n);
      n_chk++; if ({K_8, dataOut_8} !== ex[i] || grantA_8 !== g[i]) begin
        n_fail++; $display("FAIL skp_sym%0d got sym=%h gA=%b want sym=%h gA=%b",
                           i, {K_8, dataOut_8}, grantA_8, ex[i], g[i]); end
    end
    reqA = 1'b0;
    do_reset();
    use8 = 1'b0;
  endtask

  task automatic test_enb_gap();
    logic [8:0] ex [6];
    int n, t_prev, want;
    bit bad;
    ex = '{9'h1FB, 9'h051, 9'h052, 9'h053, 9'h054, 9'h1FD};
    for (int i = 0; i < 4; i++) bytesA[i] = 8'h51 + 8'(i);
    do_reset();
    reqA = 1'b1; lenA = 4'd4;
    t_prev = 0;
    for (int i = 0; i < 6; i++) begin
      wait_stb(1'b0, n);
      if (i == 0) reqA = 1'b0;
      n_chk++; if ({K, dataOut} !== ex[i]) begin
        n_fail++; $display("FAIL gap_sym%0d got %h want %h", i, {K, dataOut}, ex[i]); end
      if (i > 0) begin
        want = (i == 2) ? 35 : 10;
        n_chk++; if (cyc - t_prev != want) begin
          n_fail++; $display("FAIL gap_spacing%0d got %0d want %0d", i, cyc - t_prev, want); end
      end
      t_prev = cyc;
      if (i == 1) begin
        repeat (3) @(negedge clk);
        enb = 1'b0;
        bad = 1'b0;
        repeat (25) begin
          @(negedge clk);
          if (symStb !== 1'b0 || popA !== 1'b0) bad = 1'b1;
        end
        enb = 1'b1;
        n_chk++; if (bad !== 1'b0) begin
          n_fail++; $display("FAIL gap_quiet got pulse=1 want 0"); end
      end
    end
  endtask

  task automatic test_async_reset();
    int n;
    for (int i = 0; i < 5; i++) bytesA[i] = 8'h61 + 8'(i);
    do_reset();
    reqA = 1'b1; lenA = 4'd5;
    wait_stb(1'b0, n);
    reqA = 1'b0;
    wait_stb(1'b0, n);
    wait_stb(1'b0, n);
    n_chk++; if ({K, dataOut, grantA} !== 10'h0C5) begin
      n_fail++; $display("FAIL areset_pre got %h want 0c5", {K, dataOut, grantA}); end
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_chk++; if ({K, dataOut} !== 9'h17C) begin
      n_fail++; $display("FAIL areset_sym got %h want 17c", {K, dataOut}); end
    n_chk++; if ({symStb, popA, grantA, busy} !== 4'b0000) begin
      n_fail++; $display("FAIL areset_ctrl got %b want 0000", {symStb, popA, grantA, busy}); end
    @(negedge clk);
    rst = 1'b1;
    wait_stb(1'b0, n);
    n_chk++; if (n != 10 || {K, dataOut} !== 9'h17C || popA !== 1'b0 || grantA !== 1'b0) begin
      n_fail++; $display("FAIL areset_after got n=%0d sym=%h pop=%b gA=%b want 10 17c 0 0",
                         n, {K, dataOut}, popA, grantA); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      bytesA[i] = 8'h00;
      bytesB[i] = 8'h00;
    end
    test_reset();
    test_single_frame();
    test_contention();
    test_len0();
    test_skp();
    test_enb_gap();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
